// File: rtl/counter_b4_pkg.sv
// Shared encodings for the 4-bit counter contract and its monitor.
package counter_b4_pkg;

  localparam int Q_W = 4;

  typedef enum logic [1:0] {
    MODE_UP3  = 2'b00,
    MODE_DN1  = 2'b01,
    MODE_UP1  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_e;

endpackage

// File: rtl/counter_b4_model.sv
// Golden next-state function of the 4-bit counter: what Q and load should be
// one edge after the given sample, and whether that step wraps the counter.
module counter_b4_model
  import counter_b4_pkg::*;
(
  input  logic           enable_i,
  input  logic [1:0]     mode_i,
  input  logic [Q_W-1:0] d_i,
  input  logic [Q_W-1:0] q_i,
  output logic [Q_W-1:0] expQ_o,
  output logic           expLoad_o,
  output logic           wrap_o
);

  always_comb begin
    expQ_o    = '0;
    expLoad_o = 1'b0;
    wrap_o    = 1'b0;
    if (enable_i) begin
      case (mode_i)
        MODE_UP3: begin
          expQ_o = q_i + Q_W'(3);
          wrap_o = (q_i >= Q_W'(13));
        end
        MODE_DN1: begin
          expQ_o = q_i - Q_W'(1);
          wrap_o = (q_i == '0);
        end
        MODE_UP1: begin
          expQ_o = q_i + Q_W'(1);
          wrap_o = (q_i == '1);
        end
        MODE_LOAD: begin
          expQ_o    = d_i;
          expLoad_o = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/counter_b4_monitor.sv
// Synthesizable scoreboard for counter_b4: predicts Q/load one edge ahead,
// flags and counts mismatches, and counts correctly observed wrap-arounds.
module counter_b4_monitor
  import counter_b4_pkg::*;
#(
  parameter int ERR_W      = 8,
  parameter int WRAP_W     = 8,
  parameter bit CHECK_LOAD = 1'b1
) (
  input  logic              b4_clk,
  input  logic              b4_reset,
  input  logic              b4_enable,
  input  logic [1:0]        b4_mode,
  input  logic [3:0]        b4_D,
  input  logic [3:0]        b4_Q,
  input  logic              b4_load,
  input  logic              b4_clr,
  output logic              b4_err,
  output logic              b4_err_sticky,
  output logic [ERR_W-1:0]  b4_err_cnt,
  output logic [WRAP_W-1:0] b4_wrap_cnt,
  output logic [3:0]        b4_expected,
  output logic              b4_tracking
);

  state_e            state_q;
  logic [Q_W-1:0]    expQ_q;
  logic              expLoad_q;
  logic              wrapPend_q;
  logic              lastDis_q;
  logic              err_q;
  logic              sticky_q;
  logic [ERR_W-1:0]  errCnt_q, errCnt_d;
  logic [WRAP_W-1:0] wrapCnt_q, wrapCnt_d;

  logic [Q_W-1:0]    modelQ;
  logic              modelLoad;
  logic              modelWrap;
  logic              tracking;
  logic              qMiss;
  logic              mismatch;
  logic              wrapHit;

  // Prediction always starts from the observed Q, which resyncs after a glitch.
  counter_b4_model u_model (
    .enable_i  (b4_enable),
    .mode_i    (b4_mode),
    .d_i       (b4_D),
    .q_i       (b4_Q),
    .expQ_o    (modelQ),
    .expLoad_o (modelLoad),
    .wrap_o    (modelWrap)
  );

  always_comb begin
    tracking  = (state_q == TRACK);
    qMiss     = (b4_Q != expQ_q);
    mismatch  = tracking && (qMiss || (CHECK_LOAD && (b4_load != expLoad_q)));
    wrapHit   = tracking && wrapPend_q && !qMiss;
    errCnt_d  = errCnt_q;
    wrapCnt_d = wrapCnt_q;
    if (b4_clr) begin
      errCnt_d  = '0;
      wrapCnt_d = '0;
    end else begin
      if (mismatch && !(&errCnt_q)) errCnt_d = errCnt_q + 1'b1;
      if (wrapHit && !(&wrapCnt_q)) wrapCnt_d = wrapCnt_q + 1'b1;
    end
  end

  always_ff @(posedge b4_clk) begin
    if (b4_reset) begin
      state_q    <= IDLE;
      expQ_q     <= '0;
      expLoad_q  <= 1'b0;
      wrapPend_q <= 1'b0;
      lastDis_q  <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      errCnt_q   <= '0;
      wrapCnt_q  <= '0;
    end else begin
      expQ_q     <= modelQ;
      expLoad_q  <= modelLoad;
      wrapPend_q <= modelWrap;
      err_q      <= mismatch;
      sticky_q   <= b4_clr ? 1'b0 : (sticky_q | mismatch);
      errCnt_q   <= errCnt_d;
      wrapCnt_q  <= wrapCnt_d;
      // Leave TRACK only after two consecutive disabled samples.
      case (state_q)
        IDLE: begin
          lastDis_q <= 1'b0;
          if (b4_enable) state_q <= TRACK;
        end
        TRACK: begin
          lastDis_q <= !b4_enable;
          if (!b4_enable && lastDis_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign b4_err        = err_q;
  assign b4_err_sticky = sticky_q;
  assign b4_err_cnt    = errCnt_q;
  assign b4_wrap_cnt   = wrapCnt_q;
  assign b4_expected   = expQ_q;
  assign b4_tracking   = tracking;

endmodule

// File: tb/tb_counter_b4_monitor.sv
// Scenario bench for counter_b4_monitor: the bench plays the counter and
// queues the monitor outputs it expects after each edge.
module tb_counter_b4_monitor;

  typedef struct packed {
    logic       err;
    logic       sticky;
    logic [7:0] errCnt;
    logic [7:0] wrapCnt;
    logic [3:0] expected;
    logic       tracking;
  } out_t;

  logic       clk = 1'b0;
  logic       b4Reset = 1'b1;
  logic       b4Enable = 1'b0;
  logic [1:0] b4Mode = 2'b00;
  logic [3:0] b4D = 4'd0;
  logic [3:0] b4Q = 4'd0;
  logic       b4Load = 1'b0;
  logic       b4Clr = 1'b0;
  logic       b4Err;
  logic       b4ErrSticky;
  logic [7:0] b4ErrCnt;
  logic [7:0] b4WrapCnt;
  logic [3:0] b4Expected;
  logic       b4Tracking;

  int   checks = 0;
  int   fails = 0;
  out_t wantQ[$];
  out_t gotQ[$];

  always #5 clk = ~clk;

  counter_b4_monitor #(.ERR_W(8), .WRAP_W(8), .CHECK_LOAD(1'b1)) dut (
    .b4_clk        (clk),
    .b4_reset      (b4Reset),
    .b4_enable     (b4Enable),
    .b4_mode       (b4Mode),
    .b4_D          (b4D),
    .b4_Q          (b4Q),
    .b4_load       (b4Load),
    .b4_clr        (b4Clr),
    .b4_err        (b4Err),
    .b4_err_sticky (b4ErrSticky),
    .b4_err_cnt    (b4ErrCnt),
    .b4_wrap_cnt   (b4WrapCnt),
    .b4_expected   (b4Expected),
    .b4_tracking   (b4Tracking)
  );

  function automatic out_t mk(input logic e, input logic s, input int ec, input int wc,
                              input int ex, input logic t);
    out_t o;
    o.err      = e;
    o.sticky   = s;
    o.errCnt   = 8'(ec);
    o.wrapCnt  = 8'(wc);
    o.expected = 4'(ex);
    o.tracking = t;
    return o;
  endfunction

  // Drive one sample, queue what the monitor must show after this edge, then capture it.
  task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] mode,
                               input logic [3:0] d, input logic [3:0] q, input logic load,
                               input logic clr, input out_t want);
    out_t got;
    @(negedge clk);
    b4Reset  = rst;
    b4Enable = en;
    b4Mode   = mode;
    b4D      = d;
    b4Q      = q;
    b4Load   = load;
    b4Clr    = clr;
    wantQ.push_back(want);
    @(posedge clk);
    #1;
    got = '{b4Err, b4ErrSticky, b4ErrCnt, b4WrapCnt, b4Expected, b4Tracking};
    gotQ.push_back(got);
  endtask

  task automatic test_reset();
    out_t w, g;
    int   idx = 0;
    applyStimulus(1, 0, 2'd0, 4'd0, 4'd0, 0, 0, mk(0, 0, 0, 0, 0, 0));
    applyStimulus(1, 1, 2'd3, 4'd9, 4'd4, 1, 1, mk(0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 2'd2, 4'd0, 4'd3, 0, 0, mk(0, 0, 0, 0, 0, 0));
    while (wantQ.size() != 0) begin
      w = wantQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g !== w) begin
        fails++;
        $display("[TB] FAIL test_reset step %0d: got err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b, required err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b",
                 idx, g.err, g.sticky, g.errCnt, g.wrapCnt, g.expected, g.tracking,
                 w.err, w.sticky, w.errCnt, w.wrapCnt, w.expected, w.tracking);
      end
      idx++;
    end
  endtask

  task automatic test_up1_wrap();
    out_t w, g;
    int   idx = 0;
    applyStimulus(1, 0, 2'd0, 4'd0,  4'd0,  0, 0, mk(0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 2'd3, 4'd14, 4'd0,  0, 0, mk(0, 0, 0, 0, 14, 1));
    applyStimulus(0, 1, 2'd2, 4'd0,  4'd14, 1, 0, mk(0, 0, 0, 0, 15, 1));
    applyStimulus(0, 1, 2'd2, 4'd0,  4'd15, 0, 0, mk(0, 0, 0, 0, 0, 1));
    applyStimulus(0, 1, 2'd2, 4'd0,  4'd0,  0, 0, mk(0, 0, 0, 1, 1, 1));
    applyStimulus(0, 1, 2'd2, 4'd0,  4'd1,  0, 0, mk(0, 0, 0, 1, 2, 1));
    while (wantQ.size() != 0) begin
      w = wantQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g !== w) begin
        fails++;
        $display("[TB] FAIL test_up1_wrap step %0d: got err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b, required err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b",
                 idx, g.err, g.sticky, g.errCnt, g.wrapCnt, g.expected, g.tracking,
                 w.err, w.sticky, w.errCnt, w.wrapCnt, w.expected, w.tracking);
      end
      idx++;
    end
  endtask

  task automatic test_up3_wrap();
    out_t w, g;
    int   idx = 0;
    applyStimulus(1, 0, 2'd0, 4'd0,  4'd0,  0, 0, mk(0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 2'd3, 4'd12, 4'd3,  0, 0, mk(0, 0, 0, 0, 12, 1));
    applyStimulus(0, 1, 2'd0, 4'd0,  4'd12, 1, 0, mk(0, 0, 0, 0, 15, 1));
    applyStimulus(0, 1, 2'd0, 4'd0,  4'd15, 0, 0, mk(0, 0, 0, 0, 2, 1));
    applyStimulus(0, 1, 2'd0, 4'd0,  4'd2,  0, 0, mk(0, 0, 0, 1, 5, 1));
    applyStimulus(0, 1, 2'd3, 4'd13, 4'd5,  0, 0, mk(0, 0, 0, 1, 13, 1));
    applyStimulus(0, 1, 2'd0, 4'd0,  4'd13, 1, 0, mk(0, 0, 0, 1, 0, 1));
    applyStimulus(0, 1, 2'd0, 4'd0,  4'd0,  0, 0, mk(0, 0, 0, 2, 3, 1));
    while (wantQ.size() != 0) begin
      w = wantQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g !== w) begin
        fails++;
        $display("[TB] FAIL test_up3_wrap step %0d: got err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b, required err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b",
                 idx, g.err, g.sticky, g.errCnt, g.wrapCnt, g.expected, g.tracking,
                 w.err, w.sticky, w.errCnt, w.wrapCnt, w.expected, w.tracking);
      end
      idx++;
    end
  endtask

  task automatic test_dn1_load_clr();
    out_t w, g;
    int   idx = 0;
    applyStimulus(1, 0, 2'd0, 4'd0, 4'd0,  0, 0, mk(0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 2'd3, 4'd1, 4'd6,  0, 0, mk(0, 0, 0, 0, 1, 1));
    applyStimulus(0, 1, 2'd1, 4'd0, 4'd1,  1, 0, mk(0, 0, 0, 0, 0, 1));
    applyStimulus(0, 1, 2'd1, 4'd0, 4'd0,  0, 0, mk(0, 0, 0, 0, 15, 1));
    applyStimulus(0, 1, 2'd1, 4'd0, 4'd15, 0, 0, mk(0, 0, 0, 1, 14, 1));
    applyStimulus(0, 1, 2'd3, 4'd9, 4'd14, 0, 0, mk(0, 0, 0, 1, 9, 1));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd9,  1, 0, mk(0, 0, 0, 1, 10, 1));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd10, 0, 1, mk(0, 0, 0, 0, 11, 1));
    while (wantQ.size() != 0) begin
      w = wantQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g !== w) begin
        fails++;
        $display("[TB] FAIL test_dn1_load_clr step %0d: got err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b, required err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b",
                 idx, g.err, g.sticky, g.errCnt, g.wrapCnt, g.expected, g.tracking,
                 w.err, w.sticky, w.errCnt, w.wrapCnt, w.expected, w.tracking);
      end
      idx++;
    end
  endtask

  task automatic test_glitch_resync();
    out_t w, g;
    int   idx = 0;
    applyStimulus(1, 0, 2'd0, 4'd0, 4'd0,  0, 0, mk(0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 2'd3, 4'd3, 4'd0,  0, 0, mk(0, 0, 0, 0, 3, 1));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd3,  1, 0, mk(0, 0, 0, 0, 4, 1));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd4,  0, 0, mk(0, 0, 0, 0, 5, 1));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd7,  0, 0, mk(1, 1, 1, 0, 8, 1));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd8,  0, 0, mk(0, 1, 1, 0, 9, 1));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd9,  1, 0, mk(1, 1, 2, 0, 10, 1));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd10, 0, 0, mk(0, 1, 2, 0, 11, 1));
    while (wantQ.size() != 0) begin
      w = wantQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g !== w) begin
        fails++;
        $display("[TB] FAIL test_glitch_resync step %0d: got err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b, required err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b",
                 idx, g.err, g.sticky, g.errCnt, g.wrapCnt, g.expected, g.tracking,
                 w.err, w.sticky, w.errCnt, w.wrapCnt, w.expected, w.tracking);
      end
      idx++;
    end
  endtask

  task automatic test_disable();
    out_t w, g;
    int   idx = 0;
    applyStimulus(1, 0, 2'd0, 4'd0, 4'd0, 0, 0, mk(0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 2'd3, 4'd4, 4'd0, 0, 0, mk(0, 0, 0, 0, 4, 1));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd4, 1, 0, mk(0, 0, 0, 0, 5, 1));
    applyStimulus(0, 0, 2'd2, 4'd0, 4'd5, 0, 0, mk(0, 0, 0, 0, 0, 1));
    applyStimulus(0, 0, 2'd2, 4'd0, 4'd3, 0, 0, mk(1, 1, 1, 0, 0, 0));
    applyStimulus(0, 0, 2'd2, 4'd0, 4'd7, 0, 0, mk(0, 1, 1, 0, 0, 0));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd9, 0, 0, mk(0, 1, 1, 0, 10, 1));
    while (wantQ.size() != 0) begin
      w = wantQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g !== w) begin
        fails++;
        $display("[TB] FAIL test_disable step %0d: got err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b, required err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b",
                 idx, g.err, g.sticky, g.errCnt, g.wrapCnt, g.expected, g.tracking,
                 w.err, w.sticky, w.errCnt, w.wrapCnt, w.expected, w.tracking);
      end
      idx++;
    end
  endtask

  task automatic test_reset_mid_track();
    out_t w, g;
    int   idx = 0;
    applyStimulus(1, 0, 2'd0, 4'd0, 4'd0,  0, 0, mk(0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 2'd3, 4'd5, 4'd0,  0, 0, mk(0, 0, 0, 0, 5, 1));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd5,  1, 0, mk(0, 0, 0, 0, 6, 1));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd0,  0, 0, mk(1, 1, 1, 0, 1, 1));
    applyStimulus(1, 1, 2'd2, 4'd0, 4'd1,  0, 0, mk(0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd11, 0, 0, mk(0, 0, 0, 0, 12, 1));
    applyStimulus(0, 1, 2'd2, 4'd0, 4'd12, 0, 0, mk(0, 0, 0, 0, 13, 1));
    while (wantQ.size() != 0) begin
      w = wantQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g !== w) begin
        fails++;
        $display("[TB] FAIL test_reset_mid_track step %0d: got err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b, required err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b",
                 idx, g.err, g.sticky, g.errCnt, g.wrapCnt, g.expected, g.tracking,
                 w.err, w.sticky, w.errCnt, w.wrapCnt, w.expected, w.tracking);
      end
      idx++;
    end
  endtask

  task automatic test_saturate_clr();
    out_t w, g;
    int   idx = 0;
    applyStimulus(1, 0, 2'd0, 4'd0, 4'd0, 0, 0, mk(0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 2'd3, 4'd0, 4'd0, 0, 0, mk(0, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 300; k++) begin
      applyStimulus(0, 1, 2'd3, 4'd0, 4'd5, 1, 0, mk(1, 1, (k > 255) ? 255 : k, 0, 0, 1));
    end
    applyStimulus(0, 1, 2'd3, 4'd0, 4'd5, 1, 1, mk(1, 0, 0, 0, 0, 1));
    applyStimulus(0, 1, 2'd3, 4'd0, 4'd0, 1, 0, mk(0, 0, 0, 0, 0, 1));
    while (wantQ.size() != 0) begin
      w = wantQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g !== w) begin
        fails++;
        $display("[TB] FAIL test_saturate_clr step %0d: got err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b, required err=%0b sticky=%0b errCnt=%0d wrap=%0d exp=%0d trk=%0b",
                 idx, g.err, g.sticky, g.errCnt, g.wrapCnt, g.expected, g.tracking,
                 w.err, w.sticky, w.errCnt, w.wrapCnt, w.expected, w.tracking);
      end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_up1_wrap();
    test_up3_wrap();
    test_dn1_load_clr();
    test_glitch_resync();
    test_disable();
    test_reset_mid_track();
    test_saturate_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
